// File: rtl/full_handshake_rx.sv
// Receive side of a four-phase req/ack clock-domain-crossing link.
// The request is brought into the clk domain through a two-flop synchronizer.
// The data word is captured once the synchronized request is seen and is
// offered to a local consumer over valid/ready. Ack goes back to the TX side
// only after the consumer has taken the word, so a slow consumer stalls TX.
module full_handshake_rx #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_i,
  input  logic [DW-1:0] req_data_i,
  output logic          ack_o,
  output logic          data_valid_o,
  output logic [DW-1:0] data_o,
  input  logic          data_ready_i,
  output logic          idle_o
);

  localparam logic [2:0] STATE_IDLE  = 3'b001;
  localparam logic [2:0] STATE_VALID = 3'b010;
  localparam logic [2:0] STATE_ACK   = 3'b100;

  logic          req_d;
  logic          req_s;
  logic [2:0]    state_r;
  logic [2:0]    next_state_s;
  logic          ack_next_s;
  logic          valid_next_s;
  logic [DW-1:0] data_next_s;
  logic          idle_next_s;

  // Two-flop synchronizer for the asynchronous request; only req_s is used.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_d <= 1'b0;
      req_s <= 1'b0;
    end else begin
      req_d <= req_i;
      req_s <= req_d;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= STATE_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode; any non-one-hot encoding recovers to idle.
  always_comb begin
    next_state_s = STATE_IDLE;
    case (state_r)
      STATE_IDLE: begin
        if (req_s) begin
          next_state_s = STATE_VALID;
        end else begin
          next_state_s = STATE_IDLE;
        end
      end
      STATE_VALID: begin
        if (data_ready_i) begin
          next_state_s = STATE_ACK;
        end else begin
          next_state_s = STATE_VALID;
        end
      end
      STATE_ACK: begin
        // Leave only after the request is seen low, so a stale req is never
        // captured a second time.
        if (!req_s) begin
          next_state_s = STATE_IDLE;
        end else begin
          next_state_s = STATE_ACK;
        end
      end
      default: begin
        next_state_s = STATE_IDLE;
      end
    endcase
  end

  // Next values of the registered outputs for the current state and inputs.
  always_comb begin
    ack_next_s   = ack_o;
    valid_next_s = data_valid_o;
    data_next_s  = data_o;
    idle_next_s  = idle_o;
    case (state_r)
      STATE_IDLE: begin
        ack_next_s = 1'b0;
        if (req_s) begin
          // TX has held the data stable for at least two clk cycles by now.
          data_next_s  = req_data_i;
          valid_next_s = 1'b1;
          idle_next_s  = 1'b0;
        end else begin
          valid_next_s = 1'b0;
          idle_next_s  = 1'b1;
        end
      end
      STATE_VALID: begin
        idle_next_s = 1'b0;
        if (data_ready_i) begin
          valid_next_s = 1'b0;
          ack_next_s   = 1'b1;
        end else begin
          valid_next_s = 1'b1;
          ack_next_s   = 1'b0;
        end
      end
      STATE_ACK: begin
        valid_next_s = 1'b0;
        if (!req_s) begin
          ack_next_s  = 1'b0;
          idle_next_s = 1'b1;
        end else begin
          ack_next_s  = 1'b1;
          idle_next_s = 1'b0;
        end
      end
      default: begin
        ack_next_s   = 1'b0;
        valid_next_s = 1'b0;
        data_next_s  = {DW{1'b0}};
        idle_next_s  = 1'b1;
      end
    endcase
  end

  // Output registers; the last word is kept in data_o after the transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_o        <= 1'b0;
      data_valid_o <= 1'b0;
      data_o       <= {DW{1'b0}};
      idle_o       <= 1'b1;
    end else begin
      ack_o        <= ack_next_s;
      data_valid_o <= valid_next_s;
      data_o       <= data_next_s;
      idle_o       <= idle_next_s;
    end
  end

endmodule

// File: tb/tb_full_handshake_rx.sv
// Directed bench for full_handshake_rx with a scoreboard of expected words.
module tb_full_handshake_rx;

  logic        clk;
  logic        tx_clk;
  logic        rst;
  logic        req_i;
  logic [31:0] req_data_i;
  logic        ack_o;
  logic        data_valid_o;
  logic [31:0] data_o;
  logic        data_ready_i;
  logic        idle_o;

  int tests;
  int fails;
  int accepts;
  logic [31:0] sb[$];

  full_handshake_rx #(.DW(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_i        (req_i),
    .req_data_i   (req_data_i),
    .ack_o        (ack_o),
    .data_valid_o (data_valid_o),
    .data_o       (data_o),
    .data_ready_i (data_ready_i),
    .idle_o       (idle_o)
  );

  // RX clock, period 10, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // TX clock, period 30, rising edges offset from every RX edge.
  initial begin
    tx_clk = 1'b0;
    #4;
    forever #15 tx_clk = ~tx_clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Consumer-side monitor: every valid&&ready seen mid-cycle is an acceptance
  // on the next edge and must match the oldest expected word.
  always @(negedge clk) begin
    logic [31:0] exp_w;
    if (!rst && data_valid_o === 1'b1 && data_ready_i === 1'b1) begin
      accepts++;
      check("sb_has_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        exp_w = sb.pop_front();
        check("accept_data", data_o, exp_w);
      end
    end
  end

  task automatic tx_send(input logic [31:0] w);
    int n;
    @(posedge tx_clk);
    req_data_i = w;
    req_i      = 1'b1;
    sb.push_back(w);
    n = 0;
    while (ack_o !== 1'b1 && n < 40) begin
      @(posedge tx_clk);
      n++;
    end
    check("b2b_ack_high", 32'(ack_o), 32'd1);
    req_i = 1'b0;
    n = 0;
    while (ack_o !== 1'b0 && n < 40) begin
      @(posedge tx_clk);
      n++;
    end
    check("b2b_ack_low", 32'(ack_o), 32'd0);
  endtask

  initial begin
    int acc0;
    tests        = 0;
    fails        = 0;
    accepts      = 0;
    rst          = 1'b1;
    req_i        = 1'b0;
    req_data_i   = 32'h0;
    data_ready_i = 1'b0;

    // Reset state
    tick(2);
    check("rst_ack", 32'(ack_o), 32'd0);
    check("rst_valid", 32'(data_valid_o), 32'd0);
    check("rst_data", data_o, 32'h0);
    check("rst_idle", 32'(idle_o), 32'd1);
    rst = 1'b0;

    // Basic transfer
    data_ready_i = 1'b1;
    req_data_i   = 32'hDEADBEEF;
    req_i        = 1'b1;
    sb.push_back(32'hDEADBEEF);
    acc0 = accepts;
    tick(2);
    check("basic_valid_e2", 32'(data_valid_o), 32'd0);
    tick(1);
    check("basic_valid_e3", 32'(data_valid_o), 32'd1);
    check("basic_data_e3", data_o, 32'hDEADBEEF);
    check("basic_idle_e3", 32'(idle_o), 32'd0);
    tick(1);
    check("basic_ack_e4", 32'(ack_o), 32'd1);
    check("basic_valid_e4", 32'(data_valid_o), 32'd0);
    req_i = 1'b0;
    tick(2);
    check("basic_ack_em1", 32'(ack_o), 32'd1);
    tick(1);
    check("basic_ack_em2", 32'(ack_o), 32'd0);
    check("basic_idle_end", 32'(idle_o), 32'd1);
    check("basic_accepts", 32'(accepts - acc0), 32'd1);

    // Backpressure
    data_ready_i = 1'b0;
    req_i        = 1'b1;
    sb.push_back(32'hDEADBEEF);
    acc0 = accepts;
    tick(3);
    check("bp_valid", 32'(data_valid_o), 32'd1);
    for (int i = 0; i < 6; i++) begin
      tick(1);
      check("bp_hold_valid", 32'(data_valid_o), 32'd1);
      check("bp_hold_data", data_o, 32'hDEADBEEF);
      check("bp_hold_ack", 32'(ack_o), 32'd0);
    end
    data_ready_i = 1'b1;
    tick(1);
    check("bp_ack", 32'(ack_o), 32'd1);
    check("bp_valid_drop", 32'(data_valid_o), 32'd0);
    data_ready_i = 1'b0;
    req_i = 1'b0;
    tick(3);
    check("bp_ack_low", 32'(ack_o), 32'd0);
    check("bp_accepts", 32'(accepts - acc0), 32'd1);

    // Held req after ack
    data_ready_i = 1'b1;
    req_data_i   = 32'hCAFEF00D;
    req_i        = 1'b1;
    sb.push_back(32'hCAFEF00D);
    acc0 = accepts;
    tick(4);
    check("held_ack_rise", 32'(ack_o), 32'd1);
    for (int i = 0; i < 20; i++) begin
      tick(1);
      check("held_ack", 32'(ack_o), 32'd1);
      check("held_valid", 32'(data_valid_o), 32'd0);
    end
    check("held_accepts", 32'(accepts - acc0), 32'd1);
    req_i = 1'b0;
    tick(3);
    check("held_ack_low", 32'(ack_o), 32'd0);

    // Back-to-back from a TX-clock four-phase model
    acc0 = accepts;
    tx_send(32'h00000001);
    tx_send(32'h00000002);
    tx_send(32'h00000003);
    tick(2);
    check("b2b_accepts", 32'(accepts - acc0), 32'd3);
    check("b2b_sb_empty", 32'(sb.size()), 32'd0);

    // Reset in STATE_ACK with req already low
    data_ready_i = 1'b1;
    req_data_i   = 32'h12345678;
    req_i        = 1'b1;
    sb.push_back(32'h12345678);
    tick(4);
    check("rack_ack_pre", 32'(ack_o), 32'd1);
    req_i = 1'b0;
    rst   = 1'b1;
    tick(1);
    rst = 1'b0;
    check("rack_ack", 32'(ack_o), 32'd0);
    check("rack_valid", 32'(data_valid_o), 32'd0);
    check("rack_data", data_o, 32'h0);
    check("rack_idle", 32'(idle_o), 32'd1);
    acc0 = accepts;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      check("rack_no_valid", 32'(data_valid_o), 32'd0);
    end
    check("rack_accepts", 32'(accepts - acc0), 32'd0);

    // Reset in STATE_VALID with req still high: re-capture 3 edges later
    data_ready_i = 1'b0;
    req_data_i   = 32'hA5A5F00F;
    req_i        = 1'b1;
    sb.push_back(32'hA5A5F00F);
    tick(3);
    check("rval_valid_pre", 32'(data_valid_o), 32'd1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("rval_valid_rst", 32'(data_valid_o), 32'd0);
    tick(2);
    check("rval_valid_r2", 32'(data_valid_o), 32'd0);
    tick(1);
    check("rval_valid_r3", 32'(data_valid_o), 32'd1);
    check("rval_data_r3", data_o, 32'hA5A5F00F);
    data_ready_i = 1'b1;
    tick(1);
    check("rval_ack", 32'(ack_o), 32'd1);
    req_i = 1'b0;
    tick(3);
    check("rval_ack_low", 32'(ack_o), 32'd0);

    // Illegal state encoding while in STATE_ACK with req high
    req_data_i = 32'h0BADC0DE;
    req_i      = 1'b1;
    sb.push_back(32'h0BADC0DE);
    tick(4);
    check("ill_ack_pre", 32'(ack_o), 32'd1);
    data_ready_i = 1'b0;
    force dut.state_r = 3'b011;
    #1;
    release dut.state_r;
    tick(1);
    check("ill_state", 32'(dut.state_r), 32'h1);
    check("ill_ack", 32'(ack_o), 32'd0);
    check("ill_valid", 32'(data_valid_o), 32'd0);
    check("ill_idle", 32'(idle_o), 32'd1);
    req_i = 1'b0;
    rst   = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(2);
    check("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
